ps2_keyboard_tx: RTL and testbench

PS2_KEYBOARD_TX -- requirements
Module: ps2_keyboard_tx

---
 rtl/ps2_keyboard_tx.sv | 194 +++++++++++++++++++
 tb/tb_ps2_keyboard_tx.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_tx.sv
// PS/2 device-side transmitter: a scancode FIFO feeding an 11-bit frame serializer.
// Both PS/2 lines are registered, so they only change on a clk edge.
//   state | meaning
//   IDLE  | lines high, waiting for a queued byte and the host inhibit to be released
//   HIGH  | ps2_clk high, the current bit is presented on ps2_data
//   LOW   | ps2_clk low, the current bit is held for the host to sample
//   GAP   | lines high, minimum idle spacing after a frame or an abort
//   HOLD  | host inhibit cut the frame short; lines high until it is released
module ps2_keyboard_tx #(
    parameter int CLK_HALF   = 4,
    parameter int GAP        = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic       host_inhibit,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy,
    output logic [4:0] fifo_count
);

    localparam int         PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [9:0] HALF_LOAD = 10'(CLK_HALF - 1);
    localparam logic [9:0] GAP_LOAD  = 10'(GAP - 1);
    localparam logic [4:0] DEPTH_CNT = 5'(FIFO_DEPTH);
    localparam logic [3:0] LAST_BIT  = 4'd10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW,
        ST_GAP,
        ST_HOLD
    } state_t;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;
    logic [7:0]       head;

    state_t     state, state_nxt;
    logic [9:0] timer, timer_nxt;
    logic [3:0] bit_idx, bit_idx_nxt;
    logic [7:0] shreg, shreg_nxt;
    logic       clk_nxt;
    logic       data_nxt;
    logic       start_ok;

    assign in_ready = (fifo_count != DEPTH_CNT);
    assign push     = in_valid && in_ready;
    assign head     = mem[rd_ptr];
    assign busy     = (state != ST_IDLE) || (fifo_count != 5'd0);
    assign start_ok = (fifo_count != 5'd0) && !host_inhibit;

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 5'd1;
                2'b01:   fifo_count <= fifo_count - 5'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Bit i of the frame: start, eight data bits LSB first, odd parity, stop.
    function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] i);
        logic r;
        case (i)
            4'd0:    r = 1'b0;
            4'd9:    r = ~^b;
            4'd10:   r = 1'b1;
            default: r = b[3'(i - 4'd1)];
        endcase
        return r;
    endfunction

    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        pop         = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    state_nxt   = ST_HIGH;
                    timer_nxt   = HALF_LOAD;
                    bit_idx_nxt = 4'd0;
                    shreg_nxt   = head;
                end
            end
            ST_HIGH: begin
                if (host_inhibit) begin
                    state_nxt = ST_HOLD;
                end else if (timer == 10'd0) begin
                    state_nxt = ST_LOW;
                    timer_nxt = HALF_LOAD;
                end else begin
                    timer_nxt = timer - 10'd1;
                end
            end
            ST_LOW: begin
                if (host_inhibit) begin
                    state_nxt = ST_HOLD;
                end else if (timer == 10'd0) begin
                    if (bit_idx == LAST_BIT) begin
                        state_nxt = ST_GAP;
                        timer_nxt = GAP_LOAD;
                        pop       = 1'b1;
                    end else begin
                        state_nxt   = ST_HIGH;
                        timer_nxt   = HALF_LOAD;
                        bit_idx_nxt = bit_idx + 4'd1;
                    end
                end else begin
                    timer_nxt = timer - 10'd1;
                end
            end
            ST_GAP: begin
                // The gap expiry passes straight through IDLE when work is pending,
                // so back-to-back frames are spaced by exactly GAP idle cycles.
                if (timer == 10'd0) begin
                    if (start_ok) begin
                        state_nxt   = ST_HIGH;
                        timer_nxt   = HALF_LOAD;
                        bit_idx_nxt = 4'd0;
                        shreg_nxt   = head;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    timer_nxt = timer - 10'd1;
                end
            end
            ST_HOLD: begin
                if (!host_inhibit) begin
                    state_nxt = ST_GAP;
                    timer_nxt = GAP_LOAD;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        clk_nxt  = (state_nxt != ST_LOW);
        data_nxt = 1'b1;
        if (state_nxt == ST_HIGH || state_nxt == ST_LOW) begin
            data_nxt = frame_bit(shreg_nxt, bit_idx_nxt);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            timer    <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            ps2_clk  <= 1'b1;
            ps2_data <= 1'b1;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            bit_idx  <= bit_idx_nxt;
            shreg    <= shreg_nxt;
            ps2_clk  <= clk_nxt;
            ps2_data <= data_nxt;
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// Bench for ps2_keyboard_tx: frame vectors, timing monitor, and a synchronising
// receiver that checks every frame against a queue of pushed bytes.
module tb_ps2_keyboard_tx;

    localparam int CLK_HALF = 4;
    localparam int GAP_C    = 8;
    localparam int DEPTH    = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       host_inhibit;
    logic       ps2_clk;
    logic       ps2_data;
    logic       busy;
    logic [4:0] fifo_count;

    always #5 clk = ~clk;

    ps2_keyboard_tx #(
        .CLK_HALF  (CLK_HALF),
        .GAP       (GAP_C),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .host_inhibit(host_inhibit),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .busy        (busy),
        .fifo_count  (fifo_count)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: actual=timeout required=event", name);
    endtask

    // Scoreboard and monitor state
    logic [7:0]  exp_q[$];
    logic [10:0] rx_q[$];
    int          rx_frames   = 0;
    int          falls_total = 0;
    int          frames_done = 0;
    int          falls       = 0;
    int          t_start     = 0;
    int          t_end       = 0;
    int          last_len    = 0;
    int          last_gap    = 0;
    int          hi_run      = 0;
    bit          in_frame    = 1'b0;
    logic        p_clk       = 1'b1;
    logic        p_dat       = 1'b1;
    logic [2:0]  s_clk       = 3'b111;
    logic [2:0]  s_dat       = 3'b111;
    logic [10:0] rbits       = '0;
    int          nb          = 0;
    int          rto         = 0;

    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            // Raw line timing: frame start = data falls while clk high; end = clk rise after 11 falls.
            if (ps2_clk === 1'b1 && ps2_data === 1'b1) hi_run++;
            else hi_run = 0;
            if (!in_frame && p_dat === 1'b1 && ps2_data === 1'b0 && ps2_clk === 1'b1) begin
                in_frame = 1'b1;
                falls    = 0;
                last_gap = cyc - t_end;
                t_start  = cyc;
            end
            if (p_clk === 1'b1 && ps2_clk === 1'b0) begin
                falls++;
                falls_total++;
            end
            if (in_frame && p_clk === 1'b0 && ps2_clk === 1'b1 && falls == 11) begin
                in_frame = 1'b0;
                t_end    = cyc;
                last_len = t_end - t_start;
                frames_done++;
            end
            if (in_frame && hi_run > 2 * CLK_HALF) in_frame = 1'b0;
            p_clk = ps2_clk;
            p_dat = ps2_data;

            // Receiver: 3-flop synchroniser, sample data on synchronised clock fall.
            s_clk = {s_clk[1:0], ps2_clk};
            s_dat = {s_dat[1:0], ps2_data};
            if (s_clk[2] === 1'b1 && s_clk[1] === 1'b0) begin
                rbits[nb] = s_dat[1];
                nb++;
                rto = 0;
                if (nb == 11) begin
                    nb = 0;
                    rx_q.push_back(rbits);
                    rx_frames++;
                    check("rx_parity", 32'(^rbits[9:1]), 32'd1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL rx_extra: actual=%0h required=no_frame", rbits);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_frame", rbits, {1'b1, ~^e, e, 1'b0});
                    end
                end
            end else if (s_clk[1] === 1'b1 && nb > 0) begin
                rto++;
                if (rto > 2 * CLK_HALF + 2) begin
                    nb  = 0;
                    rto = 0;
                end
            end
        end
    end

    // Called at a negedge; drives one push cycle and returns at the next negedge.
    task automatic push_cycle(input logic [7:0] b, input logic acc);
        in_valid = 1'b1;
        in_data  = b;
        check("push_ready", in_ready, acc);
        if (acc) exp_q.push_back(b);
        @(negedge clk);
    endtask

    task automatic wait_idle(input int budget, output int at_cyc);
        int n = 0;
        at_cyc = -1;
        while (n < budget) begin
            @(negedge clk);
            #1;
            if (busy === 1'b0 && exp_q.size() == 0) begin
                at_cyc = cyc;
                break;
            end
            n++;
        end
        if (at_cyc < 0) timeout("wait_idle");
    endtask

    task automatic wait_falls(input int target, input int budget);
        int n = 0;
        while (n < budget && !(in_frame && falls == target)) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= budget) timeout("wait_falls");
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (n < budget && frames_done < target) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= budget) timeout("wait_frames");
    endtask

    typedef struct {
        logic [7:0]  data;
        logic [10:0] frame;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int idle_at, fd0, fr0, f0, rel, bad, n;
        logic [7:0] b;

        vecs[0] = '{8'h1C, 11'h438};
        vecs[1] = '{8'hF0, 11'h7E0};
        vecs[2] = '{8'hAA, 11'h754};
        vecs[3] = '{8'h00, 11'h600};
        vecs[4] = '{8'hFF, 11'h7FE};
        vecs[5] = '{8'h01, 11'h402};
        vecs[6] = '{8'h80, 11'h500};
        vecs[7] = '{8'h7F, 11'h4FE};

        reset        = 1'b1;
        in_valid     = 1'b0;
        in_data      = 8'h00;
        host_inhibit = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ps2_clk", ps2_clk, 1'b1);
        check("rst_ps2_data", ps2_data, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_count", fifo_count, 5'd0);
        check("rst_ready", in_ready, 1'b1);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single frames: bit pattern, 22*CLK_HALF length, then GAP idle cycles.
        for (int i = 0; i < 8; i++) begin
            rx_q.delete();
            push_cycle(vecs[i].data, 1'b1);
            in_valid = 1'b0;
            wait_idle(1000, idle_at);
            if (rx_q.size() != 1) timeout("vec_rx");
            else check("vec_frame", rx_q.pop_front(), vecs[i].frame);
            check("vec_len", last_len, 22 * CLK_HALF);
            check("vec_gap", idle_at - t_end, GAP_C);
        end

        // Back-to-back 0xF0, 0x1C.
        rx_q.delete();
        fd0 = frames_done;
        push_cycle(8'hF0, 1'b1);
        push_cycle(8'h1C, 1'b1);
        in_valid = 1'b0;
        check("b2b_count2", fifo_count, 5'd2);
        wait_frames(fd0 + 1, 300);
        check("b2b_count1", fifo_count, 5'd1);
        wait_frames(fd0 + 2, 300);
        check("b2b_count0", fifo_count, 5'd0);
        check("b2b_gap", last_gap, GAP_C);
        wait_idle(300, idle_at);
        if (rx_q.size() != 2) timeout("b2b_rx");
        else begin
            check("b2b_par0", rx_q[0][9], 1'b1);
            check("b2b_par1", rx_q[1][9], 1'b0);
        end

        // Overflow: nine consecutive pushes, ninth dropped.
        fd0 = frames_done;
        fr0 = rx_frames;
        for (int i = 0; i < 9; i++) push_cycle(8'h30 + 8'(i), (i < 8) ? 1'b1 : 1'b0);
        in_valid = 1'b0;
        check("ovf_count", fifo_count, 5'd8);
        check("ovf_ready", in_ready, 1'b0);
        n = 0;
        while (n < 300 && in_ready !== 1'b1) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 300) timeout("ovf_ready_rise");
        check("ovf_ready_at_stop", cyc - t_end, 0);
        check("ovf_ready_frames", frames_done - fd0, 1);
        wait_idle(2000, idle_at);
        check("ovf_rx_total", rx_frames - fr0, 8);

        // Inhibit while idle: nothing starts until release.
        fd0 = frames_done;
        host_inhibit = 1'b1;
        push_cycle(8'h5A, 1'b1);
        in_valid = 1'b0;
        repeat (30) @(negedge clk);
        check("inh_idle_frames", frames_done - fd0, 0);
        check("inh_idle_data", ps2_data, 1'b1);
        check("inh_idle_busy", busy, 1'b1);
        check("inh_idle_count", fifo_count, 5'd1);
        host_inhibit = 1'b0;
        wait_idle(300, idle_at);
        check("inh_idle_sent", frames_done - fd0, 1);

        // Inhibit during bit 5 of 0xAA for 20 cycles, then retransmission.
        rx_q.delete();
        fd0 = frames_done;
        fr0 = rx_frames;
        push_cycle(8'hAA, 1'b1);
        in_valid = 1'b0;
        wait_falls(5, 200);
        repeat (5) @(negedge clk);
        check("hold_in_high", ps2_clk, 1'b1);
        host_inhibit = 1'b1;
        @(negedge clk);
        check("hold_next_clk", ps2_clk, 1'b1);
        check("hold_next_data", ps2_data, 1'b1);
        bad = 0;
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            if (ps2_clk !== 1'b1 || ps2_data !== 1'b1) bad++;
        end
        check("hold_lines_high", bad, 0);
        check("hold_count", fifo_count, 5'd1);
        host_inhibit = 1'b0;
        rel = cyc;
        wait_frames(fd0 + 1, 300);
        check("hold_restart", t_start - rel, GAP_C + 1);
        check("hold_len", last_len, 22 * CLK_HALF);
        check("hold_count0", fifo_count, 5'd0);
        wait_idle(300, idle_at);
        check("hold_rx_frames", rx_frames - fr0, 1);
        if (rx_q.size() != 1) timeout("hold_rx");
        else check("hold_frame", rx_q.pop_front(), 11'h754);

        // Reset during bit 3 with 3 bytes queued; a push in the reset cycle is ignored.
        push_cycle(8'h11, 1'b1);
        push_cycle(8'h22, 1'b1);
        push_cycle(8'h33, 1'b1);
        in_valid = 1'b0;
        wait_falls(3, 200);
        repeat (5) @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h77;
        @(negedge clk);
        check("mrst_clk", ps2_clk, 1'b1);
        check("mrst_data", ps2_data, 1'b1);
        check("mrst_count", fifo_count, 5'd0);
        check("mrst_busy", busy, 1'b0);
        reset    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        f0  = falls_total;
        fr0 = rx_frames;
        repeat (300) @(negedge clk);
        check("mrst_no_edges", falls_total - f0, 0);
        check("mrst_no_frames", rx_frames - fr0, 0);
        check("mrst_idle_busy", busy, 1'b0);

        // Loopback of 256 random bytes through the synchronising receiver.
        fr0 = rx_frames;
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom_range(0, 255));
            n = 0;
            while (n < 500 && in_ready !== 1'b1) begin
                @(negedge clk);
                n++;
            end
            if (n >= 500) timeout("loop_ready");
            push_cycle(b, 1'b1);
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle(40000, idle_at);
        check("loop_total", rx_frames - fr0, 256);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
